// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU controller.
// Holds the op code encodings, the result-select encodings and the controller state type.
package alu_serial_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // op[1:0] picks which slice output becomes the result bit
  localparam logic [1:0] SEL_AND  = 2'b00;
  localparam logic [1:0] SEL_OR   = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b10;
  localparam logic [1:0] SEL_LESS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_serial_ctrl_slice.sv
// Combinational 1-bit ALU slice: optional b inversion, full adder and a 4:1 result select.
module alu_bit_slice
  import alu_serial_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] op,
  output logic       result,
  output logic       cout,
  output logic       sum
);

  logic b_eff;

  assign b_eff = op[2] ? ~b : b;
  assign sum   = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (cin & (a ^ b_eff));

  always_comb begin
    result = 1'b0;
    case (op[1:0])
      SEL_AND:  result = a & b_eff;
      SEL_OR:   result = a | b_eff;
      SEL_SUM:  result = sum;
      SEL_LESS: result = less;
      default:  result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: runs one alu_bit_slice over a WIDTH-bit operand pair, LSB first,
// one bit per clock, behind a valid/ready request port and a valid/ready result port.
module alu_serial_ctrl
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;

  logic             slice_result;
  logic             slice_cout;
  logic             slice_sum;
  logic             msb_overflow;
  logic [WIDTH-1:0] shifted_result;
  logic [WIDTH-1:0] final_result;

  // The LESS bit is patched in after the MSB is known, so the slice's less input stays 0.
  alu_bit_slice u_slice (
    .a      (a_q[cnt_q]),
    .b      (b_q[cnt_q]),
    .cin    (carry_q),
    .less   (1'b0),
    .op     (op_q),
    .result (slice_result),
    .cout   (slice_cout),
    .sum    (slice_sum)
  );

  assign msb_overflow   = carry_q ^ slice_cout;
  assign shifted_result = {slice_result, result_q[WIDTH-1:1]};
  assign final_result   = (op_q[1:0] == SEL_LESS)
                          ? {{(WIDTH-1){1'b0}}, slice_sum ^ msb_overflow}
                          : shifted_result;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    zero_d     = zero_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          carry_d = op[2];
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d  = slice_cout;
        result_d = shifted_result;
        if (cnt_q == CNT_LAST) begin
          result_d   = final_result;
          zero_d     = ~|final_result;
          cout_d     = slice_cout;
          overflow_d = msb_overflow;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed, table-driven bench for alu_serial_ctrl with hand-computed expected results,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_alu_serial_ctrl;

  localparam int W = 32;
  localparam int LAT = W;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          cout;
  logic          overflow;

  int compared   = 0;
  int mismatched = 0;

  vec_t vecs[10];

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .cout      (cout),
    .overflow  (overflow)
  );

  task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where out_valid is first seen high.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                               input logic [2:0] opv, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkVal("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    a = av;
    b = bv;
    op = opv;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    op = 3'b011;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int lat);
    checkVal({v.name, "_latency"}, 32'(lat), 32'(LAT));
    checkVal({v.name, "_result"}, result, v.exp_result);
    checkVal({v.name, "_zero"}, {31'b0, zero}, {31'b0, v.exp_zero});
    checkVal({v.name, "_cout"}, {31'b0, cout}, {31'b0, v.exp_cout});
    checkVal({v.name, "_overflow"}, {31'b0, overflow}, {31'b0, v.exp_ovf});
  endtask

  initial begin
    int lat;
    int seen;
    vec_t v;

    vecs[0] = '{"add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{"sub_neg",    32'h0000_0005, 32'h0000_0007, 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"slt_true",   32'h8000_0000, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{"slt_ovf",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b111, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{"slt_equal",  32'h0000_0003, 32'h0000_0003, 3'b111, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{"and",        32'hF0F0_A5A5, 32'h0FF0_5AA5, 3'b000, 32'h00F0_00A5, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{"or",         32'hF0F0_A5A5, 32'h0FF0_5AA5, 3'b001, 32'hFFF0_FFA5, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{"and_notb",   32'hF0F0_A5A5, 32'h0FF0_5AA5, 3'b100, 32'hF000_A500, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{"or_notb",    32'hF0F0_A5A5, 32'h0FF0_5AA5, 3'b101, 32'hF0FF_A5FF, 1'b0, 1'b1, 1'b0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = '0;
    repeat (3) @(negedge clk);

    checkVal("reset_in_ready",  {31'b0, in_ready},  32'd1);
    checkVal("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkVal("reset_result",    result,             32'd0);
    checkVal("reset_zero",      {31'b0, zero},      32'd0);
    checkVal("reset_cout",      {31'b0, cout},      32'd0);
    checkVal("reset_overflow",  {31'b0, overflow},  32'd0);

    reset_n = 1'b1;
    @(negedge clk);

    // Table vectors with out_ready held high: out_valid must pulse for exactly one cycle.
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      applyStimulus(v.a, v.b, v.op, lat);
      checkOutput(v, lat);
      @(negedge clk);
      checkVal({v.name, "_pulse_valid"}, {31'b0, out_valid}, 32'd0);
      checkVal({v.name, "_back_idle"},   {31'b0, in_ready},  32'd1);
    end

    // Backpressure: result held for 10 cycles while a competing request is offered.
    out_ready = 1'b0;
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 3'b010, lat);
    checkVal("bp_latency", 32'(lat), 32'(LAT));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = 32'(i + 100);
      b = 32'(i);
      op = 3'b010;
      @(negedge clk);
      checkVal("bp_out_valid", {31'b0, out_valid}, 32'd1);
      checkVal("bp_in_ready",  {31'b0, in_ready},  32'd0);
      checkVal("bp_result",    result,             32'h8000_0000);
      checkVal("bp_overflow",  {31'b0, overflow},  32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkVal("bp_release_valid", {31'b0, out_valid}, 32'd0);
    checkVal("bp_release_ready", {31'b0, in_ready},  32'd1);
    checkVal("bp_idle_result",   result,             32'h8000_0000);
    @(negedge clk);
    checkVal("bp_no_queued_req", {31'b0, in_ready},  32'd1);

    // Reset asserted while the slice is working on bit 10.
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    op = 3'b010;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    checkVal("midrun_busy", {31'b0, in_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    checkVal("abort_in_ready",  {31'b0, in_ready},  32'd1);
    checkVal("abort_out_valid", {31'b0, out_valid}, 32'd0);
    checkVal("abort_result",    result,             32'd0);
    checkVal("abort_zero",      {31'b0, zero},      32'd0);
    checkVal("abort_cout",      {31'b0, cout},      32'd0);
    checkVal("abort_overflow",  {31'b0, overflow},  32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkVal("abort_no_valid", 32'(seen), 32'd0);

    v = '{"post_reset_add", 32'd2, 32'd3, 3'b010, 32'd5, 1'b0, 1'b0, 1'b0};
    applyStimulus(v.a, v.b, v.op, lat);
    checkOutput(v, lat);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial ALU controller that sequences a single 1-bit ALU slice over a WIDTH-bit operand pair, one bit per clock, LSB first. It latches operands and a 3-bit op code through a valid/ready handshake. It carries the slice's carry-out between cycles and assembles result, zero, carry-out and overflow. It sits between the datapath register file and the writeback stage wherever area matters more than throughput.

## Interface
- WIDTH, 32: operand/result width in bits; must be ≥ 2.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request carries a valid a/b/op
- in_ready  out  1  controller can accept a request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  op code: op[2] = binvert (invert b, initial carry-in = 1); op[1:0] = result select (00 AND, 01 OR, 10 SUM, 11 LESS)
- out_valid  out  1  result fields valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- cout  out  1  carry out of bit WIDTH-1
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready = 1. If in_valid, latch a, b, op, set bit counter = 0, carry = op[2], go to RUN.
- RUN: slice inputs are a[cnt], b[cnt], carry and op. Each cycle:
  - The slice output bit shifts into the result register at the MSB end (right shift), so after WIDTH cycles bit 0 sits at result[0].
  - carry <= slice cout.
  - At cnt == WIDTH-1, capture carry-in of that bit (cmsb) and sum of that bit (smsb).
- Last RUN cycle (cnt == WIDTH-1), on the same edge:
  - cout = slice cout.
  - overflow = cmsb ^ slice cout.
  - If op[1:0] == 11: result = {WIDTH-1 zeros, smsb ^ overflow} (signed less-than).
  - zero = (final result == 0), computed from the final result value.
  - Go to DONE.
- LESS slot during RUN: every bit except bit 0 emits 0. The bit-0 value is overwritten at the end, so the slice less input is tied 0.
- DONE: out_valid = 1. result/zero/cout/overflow stay stable until out_ready is sampled high, then go to IDLE. Outputs keep their last values in IDLE.
- All 8 op codes are legal and are handled generically by binvert and select. Named ops, in package encoding:
  - AND = 000
  - OR = 001
  - ADD = 010
  - SUB = 110
  - SLT = 111
  - NOR-style variants 100/101 = a&~b, a|~b.
- in_valid outside IDLE is ignored (in_ready = 0). Inputs are sampled only at the accepting edge.

## Timing
- Reset (async assert, sync deassert by environment) forces:
  - state = IDLE, in_ready = 1, out_valid = 0
  - result = 0, zero = 0, cout = 0, overflow = 0
  - counter = 0, carry = 0
- Accept edge = E0. RUN occupies the WIDTH cycles after E0. out_valid rises after edge E0+WIDTH, so latency is WIDTH cycles.
- Minimum request spacing is WIDTH+2 cycles: DONE lasts ≥ 1 cycle, then ≥ 1 IDLE cycle.
- If out_ready is already high when DONE is entered, out_valid is high for exactly one cycle.
- Reset during RUN or DONE aborts the operation. No out_valid is produced for the aborted request.
- Counter is $clog2(WIDTH) bits and never wraps inside a request. It is cleared on accept.

## Structure
- Package alu_serial_pkg holds:
  - op code localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT)
  - select encodings (SEL_AND/OR/SUM/LESS)
  - state enum typedef (IDLE/RUN/DONE)
- One sub-module, alu_bit_slice: combinational 1-bit slice.
  - Inputs: a, b, cin, less, op.
  - Outputs: result, cout, sum.
  - Behaviour: b muxed with ~b by op[2]; full adder; 4:1 select.
- Controller instantiates exactly one alu_bit_slice.

## Test plan
- ADD a=0xFFFF_FFFF, b=0x0000_0001 -> result 0, zero=1, cout=1, overflow=0. out_valid exactly 32 cycles after accept.
- SUB a=5, b=7 -> result 0xFFFF_FFFE, zero=0, cout=0, overflow=0. Also ADD 0x7FFF_FFFF+1 -> 0x8000_0000, overflow=1.
- SLT a=0x8000_0000, b=1 -> result 1. SLT a=0x7FFF_FFFF, b=0xFFFF_FFFF (overflow case) -> result 0. SLT a=b=3 -> result 0, zero=1.
- AND/OR a=0xF0F0_A5A5, b=0x0FF0_5AA5 -> AND 0x00F0_00A5, OR 0xFFF0_FFA5. op=100 -> a&~b = 0xF000_A500.
- Backpressure: out_ready low 10 cycles after out_valid. Outputs and out_valid stay stable, in_ready stays 0, a new in_valid is ignored. out_ready high -> IDLE the next cycle.
- Reset asserted mid-RUN at bit 10 -> all outputs return to reset values immediately. After release, a fresh ADD 2+3 -> 5 with normal latency.
